// File: rtl/dte_pkg.sv
// dte_pkg: shared types for the KL10 DTE diagnostic sequencer.
// The request timestamp field exists only when DTE_SEQ_TIMEGATE_EN is defined.
package dte_pkg;

    localparam int DTE_TIMEW_MAX = 64;

    typedef enum logic [2:0] {
        REQ_MISC    = 3'd0,
        REQ_WRITE   = 3'd1,
        REQ_DIAG    = 3'd2,
        REQ_READ    = 3'd3,
        REQ_RELEASE = 3'd4
    } tDteReqType;

    typedef enum logic [6:0] {
        MISC_CLR_CROBAR = 7'd0,
        MISC_GET_APRID  = 7'd1,
        MISC_WRITE_MEM  = 7'd2,
        MISC_GET_DIAG1  = 7'd3
    } tDteMiscOp;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TIME,
        ST_STROBE,
        ST_SAMPLE,
        ST_REPLY
    } tDteState;

    typedef struct packed {
        tDteReqType                 rtype;
        logic [6:0]                 func;
`ifdef DTE_SEQ_TIMEGATE_EN
        logic [DTE_TIMEW_MAX-1:0]   rtime;
`endif
        logic [35:0]                data1;
        logic [35:0]                data2;
    } tDteReq;

    // Reply word (LH,,RH) for the opcodes that return status.
    function automatic logic [35:0] dte_misc_reply(
        input logic [6:0]  func,
        input logic [17:0] ucode_id,
        input logic [17:0] hw_options,
        input logic        con_run,
        input logic        con_ebox_halted
    );
        case (func)
            MISC_GET_APRID: return {ucode_id, hw_options};
            MISC_GET_DIAG1: return {18'b0, 16'b0, con_run, con_ebox_halted};
            default:        return '0;
        endcase
    endfunction

endpackage

// File: rtl/dte_req_fifo.sv
// dte_req_fifo: synchronous FIFO of DTE request structs with count/full/empty.
// When full, a push is still taken if a pop happens in the same cycle.
module dte_req_fifo
    import dte_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  tDteReq                 data_i,
    input  logic                   pop_i,
    output tDteReq                 data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    tDteReq        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: flops take <= so every register in the block sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: entries are not reset; validity lives in the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/dte_diag_sequencer.sv
// dte_diag_sequencer: queued, time-gated console-to-EBUS diagnostic sequencer.
// Define DTE_SEQ_TIMEGATE_EN to hold each request until ticks >= req_time.
module dte_diag_sequencer
    import dte_pkg::*;
#(
    parameter int QDEPTH        = 4,
    parameter int TIMEW         = 64,
    parameter int STROBE_CYCLES = 2,
    parameter int MEMAW         = 18
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_type,
    input  logic [6:0]              req_func,
    input  logic [TIMEW-1:0]        req_time,
    input  logic [35:0]             req_data1,
    input  logic [35:0]             req_data2,
    output logic                    rep_valid,
    input  logic                    rep_ready,
    output logic [TIMEW-1:0]        rep_time,
    output logic [17:0]             rep_lh,
    output logic [17:0]             rep_rh,
    input  logic [35:0]             ebus_data,
    output logic [6:0]              ebus_ds,
    output logic                    ebus_diag_strobe,
    output logic                    ebus_drive,
    output logic [35:0]             ebus_drive_data,
    output logic                    mem_we,
    output logic [MEMAW-1:0]        mem_addr,
    output logic [35:0]             mem_wdata,
    input  logic [17:0]             ucode_id,
    input  logic [17:0]             hw_options,
    input  logic                    con_run,
    input  logic                    con_ebox_halted,
    output logic                    crobar,
    output logic [$clog2(QDEPTH):0] q_count
);

    localparam int SCW = $clog2(STROBE_CYCLES) + 1;
    localparam logic [SCW-1:0] STROBE_LAST = SCW'(STROBE_CYCLES - 1);

    tDteState          state_q, state_d;
    tDteReq            cur_q, cur_d;
    tDteReq            push_req, fifo_dout;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [TIMEW-1:0]  ticks_q;
    logic [SCW-1:0]    strobe_cnt_q, strobe_cnt_d;
    logic [TIMEW-1:0]  rep_time_q, rep_time_d;
    logic [17:0]       rep_lh_q, rep_lh_d, rep_rh_q, rep_rh_d;
    logic [6:0]        ds_q, ds_d;
    logic              strobe_q, strobe_d;
    logic              drive_q, drive_d;
    logic [35:0]       drive_data_q, drive_data_d;
    logic              mem_we_q, mem_we_d;
    logic [MEMAW-1:0]  mem_addr_q, mem_addr_d;
    logic [35:0]       mem_wdata_q, mem_wdata_d;
    logic              crobar_q, crobar_d;
    logic              time_ok;
    logic [35:0]       misc_word;

    always_comb begin
        push_req       = '0;
        push_req.rtype = tDteReqType'(req_type);
        push_req.func  = req_func;
        push_req.data1 = req_data1;
        push_req.data2 = req_data2;
`ifdef DTE_SEQ_TIMEGATE_EN
        push_req.rtime = DTE_TIMEW_MAX'(req_time);
`endif
    end

`ifdef DTE_SEQ_TIMEGATE_EN
    // Plain unsigned compare: a timestamp behind a wrapped counter waits a full wrap.
    assign time_ok = (ticks_q >= cur_q.rtime[TIMEW-1:0]);
`else
    logic unused_req_time;
    assign unused_req_time = ^req_time;
    assign time_ok         = 1'b1;
`endif

    dte_req_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .push_i  (req_valid && req_ready),
        .data_i  (push_req),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .count_o (q_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign misc_word = dte_misc_reply(cur_q.func, ucode_id, hw_options,
                                      con_run, con_ebox_halted);

    // NOTE: every _d starts from its hold value so no branch can infer a latch.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        strobe_cnt_d = strobe_cnt_q;
        rep_time_d   = rep_time_q;
        rep_lh_d     = rep_lh_q;
        rep_rh_d     = rep_rh_q;
        ds_d         = ds_q;
        strobe_d     = strobe_q;
        drive_d      = drive_q;
        drive_data_d = drive_data_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        crobar_d     = crobar_q;
        fifo_pop     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = fifo_dout;
                    state_d  = ST_WAIT_TIME;
                end
            end

            ST_WAIT_TIME: begin
                if (time_ok) begin
                    case (cur_q.rtype)
                        REQ_MISC: begin
                            if (cur_q.func == MISC_CLR_CROBAR) crobar_d = 1'b0;
                            if (cur_q.func == MISC_WRITE_MEM) begin
                                mem_we_d    = 1'b1;
                                mem_addr_d  = cur_q.data1[MEMAW-1:0];
                                mem_wdata_d = cur_q.data2;
                            end
                            state_d = ST_SAMPLE;
                        end
                        REQ_WRITE, REQ_DIAG: begin
                            if (cur_q.rtype == REQ_WRITE) begin
                                drive_d      = 1'b1;
                                drive_data_d = cur_q.data1;
                            end
                            ds_d         = cur_q.func;
                            strobe_d     = 1'b1;
                            strobe_cnt_d = '0;
                            state_d      = ST_STROBE;
                        end
                        REQ_RELEASE: begin
                            drive_d      = 1'b0;
                            drive_data_d = '0;
                            strobe_d     = 1'b0;
                            state_d      = ST_SAMPLE;
                        end
                        default: state_d = ST_SAMPLE;
                    endcase
                end
            end

            ST_STROBE: begin
                if (strobe_cnt_q == STROBE_LAST) state_d = ST_SAMPLE;
                else                             strobe_cnt_d = strobe_cnt_q + SCW'(1);
            end

            // MISC requests also pass through here so every non-strobe type has equal latency.
            ST_SAMPLE: begin
                rep_time_d = ticks_q;
                if (cur_q.rtype == REQ_MISC) begin
                    rep_lh_d = misc_word[35:18];
                    rep_rh_d = misc_word[17:0];
                end else begin
                    rep_lh_d = ebus_data[35:18];
                    rep_rh_d = ebus_data[17:0];
                end
                state_d = ST_REPLY;
            end

            ST_REPLY: begin
                if (rep_ready) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            ticks_q      <= '0;
            strobe_cnt_q <= '0;
            rep_time_q   <= '0;
            rep_lh_q     <= '0;
            rep_rh_q     <= '0;
            ds_q         <= '0;
            strobe_q     <= 1'b0;
            drive_q      <= 1'b0;
            drive_data_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            crobar_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            ticks_q      <= ticks_q + TIMEW'(1);
            strobe_cnt_q <= strobe_cnt_d;
            rep_time_q   <= rep_time_d;
            rep_lh_q     <= rep_lh_d;
            rep_rh_q     <= rep_rh_d;
            ds_q         <= ds_d;
            strobe_q     <= strobe_d;
            drive_q      <= drive_d;
            drive_data_q <= drive_data_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            crobar_q     <= crobar_d;
        end
    end

    assign req_ready        = !fifo_full;
    assign rep_valid        = (state_q == ST_REPLY);
    assign rep_time         = rep_time_q;
    assign rep_lh           = rep_lh_q;
    assign rep_rh           = rep_rh_q;
    assign ebus_ds          = ds_q;
    assign ebus_diag_strobe = strobe_q;
    assign ebus_drive       = drive_q;
    assign ebus_drive_data  = drive_data_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign crobar           = crobar_q;

endmodule

// File: tb/tb_dte_diag_sequencer.sv
// tb_dte_diag_sequencer: directed self-checking bench for dte_diag_sequencer.
// Expected values are hand-computed for QDEPTH=4, STROBE_CYCLES=2, MEMAW=18.
`timescale 1ns/1ps
module tb_dte_diag_sequencer;
    import dte_pkg::*;

    localparam int QDEPTH        = 4;
    localparam int TIMEW         = 64;
    localparam int STROBE_CYCLES = 2;
    localparam int MEMAW         = 18;
    localparam logic [35:0] BUS_IDLE = 36'o525252252525;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_type = '0;
    logic [6:0]        req_func = '0;
    logic [TIMEW-1:0]  req_time = '0;
    logic [35:0]       req_data1 = '0;
    logic [35:0]       req_data2 = '0;
    logic              rep_valid;
    logic              rep_ready = 1'b0;
    logic [TIMEW-1:0]  rep_time;
    logic [17:0]       rep_lh, rep_rh;
    logic [35:0]       ebus_data;
    logic [6:0]        ebus_ds;
    logic              ebus_diag_strobe, ebus_drive;
    logic [35:0]       ebus_drive_data;
    logic              mem_we;
    logic [MEMAW-1:0]  mem_addr;
    logic [35:0]       mem_wdata;
    logic [17:0]       ucode_id = 18'o123456;
    logic [17:0]       hw_options = 18'o000017;
    logic              con_run = 1'b1;
    logic              con_ebox_halted = 1'b0;
    logic              crobar;
    logic [$clog2(QDEPTH):0] q_count;

    int vectors = 0;
    int miscompares = 0;
    int lat, strobe_at, we_cnt, we_at, seen_valid;
    logic [MEMAW-1:0] we_addr;
    logic [35:0]      we_data;
    int cyc;

    logic [17:0] exp_lh [5];
    logic [17:0] exp_rh [5];

    assign ebus_data = ebus_drive ? ebus_drive_data : BUS_IDLE;

    always #8.333 CLK = ~CLK;

    // Free-running cycle count that tracks the DUT tick counter from reset.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    dte_diag_sequencer #(
        .QDEPTH(QDEPTH), .TIMEW(TIMEW), .STROBE_CYCLES(STROBE_CYCLES), .MEMAW(MEMAW)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_func(req_func), .req_time(req_time), .req_data1(req_data1), .req_data2(req_data2),
        .rep_valid(rep_valid), .rep_ready(rep_ready), .rep_time(rep_time),
        .rep_lh(rep_lh), .rep_rh(rep_rh),
        .ebus_data(ebus_data), .ebus_ds(ebus_ds), .ebus_diag_strobe(ebus_diag_strobe),
        .ebus_drive(ebus_drive), .ebus_drive_data(ebus_drive_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ucode_id(ucode_id), .hw_options(hw_options),
        .con_run(con_run), .con_ebox_halted(con_ebox_halted),
        .crobar(crobar), .q_count(q_count)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0o expected %0o", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic push(input tDteReqType t, input logic [6:0] f, input logic [63:0] tm,
                        input logic [35:0] d1, input logic [35:0] d2);
        @(negedge CLK);
        req_valid = 1'b1;
        req_type  = t;
        req_func  = f;
        req_time  = tm;
        req_data1 = d1;
        req_data2 = d2;
        @(posedge CLK);
        #1 req_valid = 1'b0;
    endtask

    // Counts negedges from the pop cycle (index 0) until rep_valid, bounded.
    task automatic wait_reply();
        lat = 0; strobe_at = -1; we_cnt = 0; we_at = -1;
        @(negedge CLK);
        while (!rep_valid && lat < 300) begin
            if (ebus_diag_strobe && strobe_at < 0) strobe_at = lat;
            if (mem_we) begin
                we_cnt++;
                we_at   = lat;
                we_addr = mem_addr;
                we_data = mem_wdata;
            end
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic take_reply();
        rep_ready = 1'b1;
        @(posedge CLK);
        #1 rep_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_lh[0] = 18'o123456; exp_rh[0] = 18'o000017;
        exp_lh[1] = 18'o0;      exp_rh[1] = 18'o000002;
        exp_lh[2] = 18'o525252; exp_rh[2] = 18'o252525;
        exp_lh[3] = 18'o0;      exp_rh[3] = 18'o0;
        exp_lh[4] = 18'o123456; exp_rh[4] = 18'o000017;

        // Reset state, sampled while reset is held.
        #20;
        check("rst crobar",    64'(crobar), 64'd1);
        check("rst req_ready", 64'(req_ready), 64'd1);
        check("rst rep_valid", 64'(rep_valid), 64'd0);
        check("rst q_count",   64'(q_count), 64'd0);
        check("rst strobe",    64'(ebus_diag_strobe), 64'd0);
        check("rst drive",     64'(ebus_drive), 64'd0);
        check("rst mem_we",    64'(mem_we), 64'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // GET_APRID: reply three cycles after the pop.
        push(REQ_MISC, MISC_GET_APRID, 64'd0, 36'd0, 36'd0);
        wait_reply();
        check("aprid latency", 64'(lat), 64'd3);
        check("aprid lh", 64'(rep_lh), 64'(18'o123456));
        check("aprid rh", 64'(rep_rh), 64'(18'o000017));
        take_reply();

        // WRITE with the bus looped back from the driver.
        push(REQ_WRITE, 7'o71, 64'd0, 36'o111111222222, 36'd0);
        wait_reply();
        check("write latency",   64'(lat), 64'(3 + STROBE_CYCLES));
        check("write strobe_at", 64'(strobe_at), 64'd2);
        check("write ds",        64'(ebus_ds), 64'(7'o71));
        check("write lh",        64'(rep_lh), 64'(18'o111111));
        check("write rh",        64'(rep_rh), 64'(18'o222222));
        take_reply();
        push(REQ_READ, 7'd0, 64'd0, 36'd0, 36'd0);
        wait_reply();
        check("read latency",     64'(lat), 64'd3);
        check("driver held",      64'(ebus_drive), 64'd1);
        check("strobe held",      64'(ebus_diag_strobe), 64'd1);
        check("read looped lh",   64'(rep_lh), 64'(18'o111111));
        take_reply();
        push(REQ_RELEASE, 7'd0, 64'd0, 36'd0, 36'd0);
        wait_reply();
        check("release latency", 64'(lat), 64'd3);
        check("release drive",   64'(ebus_drive), 64'd0);
        check("release strobe",  64'(ebus_diag_strobe), 64'd0);
        check("release lh",      64'(rep_lh), 64'(18'o525252));
        check("release rh",      64'(rep_rh), 64'(18'o252525));
        take_reply();

        // Five back-to-back pushes under reply backpressure.
        push(REQ_MISC, MISC_GET_APRID, 64'd0, 36'd0, 36'd0);
        push(REQ_MISC, MISC_GET_DIAG1, 64'd0, 36'd0, 36'd0);
        push(REQ_READ, 7'd0, 64'd0, 36'd0, 36'd0);
        push(REQ_MISC, 7'd5, 64'd0, 36'd0, 36'd0);
        push(REQ_MISC, MISC_GET_APRID, 64'd0, 36'd0, 36'd0);
        check("full req_ready", 64'(req_ready), 64'd0);
        check("full q_count",   64'(q_count), 64'd4);
        repeat (3) @(negedge CLK);
        check("stall valid", 64'(rep_valid), 64'd1);
        check("stall lh",    64'(rep_lh), 64'(18'o123456));
        for (int i = 0; i < 5; i++) begin
            wait_reply();
            check($sformatf("b2b valid %0d", i), 64'(rep_valid), 64'd1);
            check($sformatf("b2b lh %0d", i), 64'(rep_lh), 64'(exp_lh[i]));
            check($sformatf("b2b rh %0d", i), 64'(rep_rh), 64'(exp_rh[i]));
            take_reply();
        end
        check("drained q_count", 64'(q_count), 64'd0);
        check("drained ready",   64'(req_ready), 64'd1);

        // WRITE_MEM: single mem_we pulse in the cycle after WAIT_TIME.
        push(REQ_MISC, MISC_WRITE_MEM, 64'd0, 36'o000000000200, 36'o777);
        wait_reply();
        check("wmem latency", 64'(lat), 64'd3);
        check("wmem pulses",  64'(we_cnt), 64'd1);
        check("wmem we_at",   64'(we_at), 64'd2);
        check("wmem addr",    64'(we_addr), 64'(18'o200));
        check("wmem data",    64'(we_data), 64'(36'o777));
        check("wmem reply",   64'({rep_lh, rep_rh}), 64'd0);
        take_reply();
        check("wmem we low", 64'(mem_we), 64'd0);

        // CLR_CROBAR is sticky until reset.
        push(REQ_MISC, MISC_CLR_CROBAR, 64'd0, 36'd0, 36'd0);
        wait_reply();
        check("clr crobar",  64'(crobar), 64'd0);
        check("clr reply",   64'({rep_lh, rep_rh}), 64'd0);
        take_reply();

        // Reset in the middle of STROBE with a request still queued.
        push(REQ_WRITE, 7'o12, 64'd0, 36'o707070707070, 36'd0);
        push(REQ_READ, 7'd0, 64'd0, 36'd0, 36'd0);
        @(negedge CLK);
        @(negedge CLK);
        check("pre-rst strobe", 64'(ebus_diag_strobe), 64'd1);
        check("pre-rst drive",  64'(ebus_drive), 64'd1);
        #2 RESET_N = 1'b0;
        #1;
        check("arst strobe",  64'(ebus_diag_strobe), 64'd0);
        check("arst drive",   64'(ebus_drive), 64'd0);
        check("arst valid",   64'(rep_valid), 64'd0);
        check("arst q_count", 64'(q_count), 64'd0);
        check("arst crobar",  64'(crobar), 64'd1);
        check("arst ready",   64'(req_ready), 64'd1);
        @(negedge CLK);
        RESET_N = 1'b1;
        seen_valid = 0;
        repeat (20) begin
            @(negedge CLK);
            if (rep_valid) seen_valid++;
        end
        check("no reply after reset", 64'(seen_valid), 64'd0);

        // Timestamped READ pushed while ticks == 10.
        do_reset();
        while (cyc != 10) @(negedge CLK);
        req_valid = 1'b1;
        req_type  = REQ_READ;
        req_func  = '0;
        req_time  = 64'd100;
        req_data1 = '0;
        req_data2 = '0;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        wait_reply();
`ifdef DTE_SEQ_TIMEGATE_EN
        check("gate latency",  64'(lat), 64'd91);
        check("gate rep_time", 64'(rep_time), 64'd101);
`else
        check("nogate latency",  64'(lat), 64'd3);
        check("nogate rep_time", 64'(rep_time), 64'd13);
`endif
        check("gate lh", 64'(rep_lh), 64'(18'o525252));
        take_reply();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
